// File: rtl/adc0809_ctrl.sv
// ADC0809 conversion controller: generates the ADC clock and control strobes, waits for EOC
// through a two-flop synchroniser and captures the result byte with a one-cycle valid pulse.
module adc0809_ctrl #(
    parameter int CLK_DIV = 40,
    parameter int START_W = 4,
    parameter int OE_W    = 4,
    parameter int TIMEOUT = 200000,
    parameter bit AUTO    = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req,
    input  logic [2:0] ch,
    input  logic       eoc,
    input  logic [7:0] adc_d,
    output logic       adc_clk,
    output logic       ale,
    output logic       start,
    output logic       oe,
    output logic [2:0] addr,
    output logic       busy,
    output logic [7:0] data_out,
    output logic       data_valid,
    output logic       err
);
    localparam int DW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int TMAX = (TIMEOUT > START_W) ? ((TIMEOUT > OE_W) ? TIMEOUT : OE_W)
                                              : ((START_W > OE_W) ? START_W : OE_W);
    localparam int TW   = $clog2(TMAX + 1);

    typedef enum logic [2:0] {S_IDLE, S_START, S_WAIT_LO, S_WAIT_HI, S_READ} state_t;

    state_t        state, state_nx;
    logic [DW-1:0] div_cnt;
    logic [TW-1:0] timer;
    logic          eoc_m, eoc_s;
    logic          start_done, read_done, timed_out;

    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            div_cnt <= '0;
            adc_clk <= 1'b0;
        end else if (div_cnt == DW'(CLK_DIV - 1)) begin
            div_cnt <= '0;
            adc_clk <= ~adc_clk;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end

    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            eoc_m <= 1'b0;
            eoc_s <= 1'b0;
        end else begin
            eoc_m <= eoc;
            eoc_s <= eoc_m;
        end

    assign start_done = (timer == TW'(START_W - 1));
    assign read_done  = (timer == TW'(OE_W - 1));
    assign timed_out  = (timer == TW'(TIMEOUT - 1));

    // One timer serves every state: cleared on any transition, parked at the abort count.
    always_ff @(posedge clk or negedge rst)
        if (!rst)                   timer <= '0;
        else if (state_nx != state) timer <= '0;
        else if (!timed_out)        timer <= timer + 1'b1;

    always_ff @(posedge clk or negedge rst)
        if (!rst) state <= S_IDLE;
        else      state <= state_nx;

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:    if (req || AUTO) state_nx = S_START;
            S_START:   if (start_done)  state_nx = S_WAIT_LO;
            S_WAIT_LO: if (!eoc_s)      state_nx = S_WAIT_HI;
                       else if (timed_out) state_nx = S_IDLE;
            S_WAIT_HI: if (eoc_s)       state_nx = S_READ;
                       else if (timed_out) state_nx = S_IDLE;
            S_READ:    if (read_done)   state_nx = S_IDLE;
            default:                    state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        ale   = 1'b0;
        start = 1'b0;
        oe    = 1'b0;
        busy  = (state != S_IDLE);
        case (state)
            S_START: begin
                ale   = 1'b1;
                start = 1'b1;
            end
            S_READ:  oe = 1'b1;
            default: ;
        endcase
    end

    // An EOC edge arriving on the last allowed cycle wins over the abort.
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            addr       <= 3'd0;
            data_out   <= 8'h00;
            data_valid <= 1'b0;
            err        <= 1'b0;
        end else begin
            data_valid <= (state == S_READ) && read_done;
            err        <= timed_out && (((state == S_WAIT_LO) && eoc_s) ||
                                        ((state == S_WAIT_HI) && !eoc_s));
            if ((state == S_IDLE) && (state_nx == S_START)) addr <= ch;
            if ((state == S_READ) && read_done)             data_out <= adc_d;
        end

endmodule
